// File: rtl/gray_count_reader_if.sv
// Readout-side result channel of gray_count_reader: valid/ready handshake,
// the captured count, its delta and the sticky error flags.
interface gray_count_reader_if #(
  parameter int WIDTH = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] bin_out;
  logic [WIDTH-1:0] delta_out;
  logic             glitch_err;
  logic             overrun_err;

  // Reader side produces results, consumer returns ready
  modport master (
    output out_valid,
    output bin_out,
    output delta_out,
    output glitch_err,
    output overrun_err,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  bin_out,
    input  delta_out,
    input  glitch_err,
    input  overrun_err,
    output out_ready
  );
endinterface

// File: rtl/gray_count_reader.sv
// Synchronises the gray count from the counter tree into clk_master, decodes
// it to binary, flags multi-bit gray steps and, on request, reports the
// absolute count plus the modulo-2^WIDTH delta since the last capture.
module gray_count_reader #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_master,
  input  logic                rstb,
  input  logic [WIDTH-1:0]    gray_in,
  input  logic                sample,
  input  logic                clr_err,
  gray_count_reader_if.master rd
);

  // Prime counter covers the synchroniser plus the one-cycle g_d delay
  localparam int                 PRIME_W   = $clog2(SYNC_STAGES + 2);
  localparam logic [PRIME_W-1:0] PRIME_MAX = PRIME_W'(SYNC_STAGES + 1);

  // Chained XOR from the MSB down: bin[i] = bin[i+1] ^ gray[i]
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // True when more than one bit is set (clearing the lowest set bit leaves some)
  function automatic logic multi_bit(input logic [WIDTH-1:0] x);
    return (x & (x - {{(WIDTH-1){1'b0}}, 1'b1})) != {WIDTH{1'b0}};
  endfunction

  logic [WIDTH-1:0]   sync_r [SYNC_STAGES];
  logic [WIDTH-1:0]   g_s;
  logic [WIDTH-1:0]   g_d_r;
  logic [WIDTH-1:0]   bin_r;
  logic [WIDTH-1:0]   prev_r;
  logic [PRIME_W-1:0] prime_cnt_r;
  logic               primed_s;
  logic               capture_s;
  logic               accept_s;
  logic               overrun_set_s;
  logic               glitch_set_s;
  logic [WIDTH-1:0]   delta_s;
  logic               out_valid_r;
  logic [WIDTH-1:0]   bin_out_r;
  logic [WIDTH-1:0]   delta_out_r;
  logic               glitch_err_r;
  logic               overrun_err_r;

  assign g_s      = sync_r[SYNC_STAGES-1];
  assign primed_s = (prime_cnt_r == PRIME_MAX);

  // Multi-flop synchroniser for the asynchronous gray count
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      sync_r[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // Decode register, delayed gray copy for step checking, and prime counter
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      bin_r       <= {WIDTH{1'b0}};
      g_d_r       <= {WIDTH{1'b0}};
      prime_cnt_r <= {PRIME_W{1'b0}};
    end else begin
      bin_r <= gray_to_bin(g_s);
      g_d_r <= g_s;
      if (!primed_s) begin
        prime_cnt_r <= prime_cnt_r + {{(PRIME_W-1){1'b0}}, 1'b1};
      end else begin
        prime_cnt_r <= prime_cnt_r;
      end
    end
  end

  // Handshake decisions: accept, capture (possibly coincident), drop, glitch
  always_comb begin
    accept_s      = 1'b0;
    capture_s     = 1'b0;
    overrun_set_s = 1'b0;
    glitch_set_s  = 1'b0;
    delta_s       = bin_r - prev_r;
    accept_s      = out_valid_r & rd.out_ready;
    if (sample) begin
      capture_s     = ~out_valid_r | rd.out_ready;
      overrun_set_s = out_valid_r & ~rd.out_ready;
    end else begin
      capture_s     = 1'b0;
      overrun_set_s = 1'b0;
    end
    if (primed_s) begin
      glitch_set_s = multi_bit(g_s ^ g_d_r);
    end else begin
      glitch_set_s = 1'b0;
    end
  end

  // Result registers: capture loads new data, accept alone drops valid
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      out_valid_r <= 1'b0;
      bin_out_r   <= {WIDTH{1'b0}};
      delta_out_r <= {WIDTH{1'b0}};
      prev_r      <= {WIDTH{1'b0}};
    end else if (capture_s) begin
      out_valid_r <= 1'b1;
      bin_out_r   <= bin_r;
      delta_out_r <= delta_s;
      prev_r      <= bin_r;
    end else if (accept_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Sticky error flags: a new set beats a coincident clear
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      glitch_err_r  <= 1'b0;
      overrun_err_r <= 1'b0;
    end else begin
      if (glitch_set_s) begin
        glitch_err_r <= 1'b1;
      end else if (clr_err) begin
        glitch_err_r <= 1'b0;
      end else begin
        glitch_err_r <= glitch_err_r;
      end
      if (overrun_set_s) begin
        overrun_err_r <= 1'b1;
      end else if (clr_err) begin
        overrun_err_r <= 1'b0;
      end else begin
        overrun_err_r <= overrun_err_r;
      end
    end
  end

  assign rd.out_valid   = out_valid_r;
  assign rd.bin_out     = bin_out_r;
  assign rd.delta_out   = delta_out_r;
  assign rd.glitch_err  = glitch_err_r;
  assign rd.overrun_err = overrun_err_r;

endmodule
